// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the program counter generator.
// Optional misaligned-redirect trapping is enabled with PC_MISALIGN_TRAP_EN.
package my_pkg;

   localparam int DATA_WIDTH = 32;
   localparam logic [31:0] RESET_VECTOR = 32'h0000_1000;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2
   } pc_state_t;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request handshake between the PC generator and instruction fetch.
// Width follows the PC width of the generator.
interface pc_gen_if #(
   parameter int DATA_WIDTH = 32
) ();

   logic                  fetch_valid;
   logic [DATA_WIDTH-1:0] fetch_pc;
   logic                  fetch_ready;

   modport master (
      output fetch_valid,
      output fetch_pc,
      input  fetch_ready
   );

   modport slave (
      input  fetch_valid,
      input  fetch_pc,
      output fetch_ready
   );

endinterface

// File: rtl/pc_gen_next_sel.sv
// Next-PC and next-state priority mux for the PC generator.
// PC_MISALIGN_TRAP_EN rejects misaligned redirect targets instead of masking.
module pc_next_sel #(
   parameter int DATA_WIDTH = 32,
   parameter int PC_INCR    = 4
) (
   input  my_pkg::pc_state_t      state,
   input  logic [DATA_WIDTH-1:0]  pc,
   input  logic                   fetch_valid,
   input  logic                   fetch_ready,
   input  logic                   stall,
   input  logic                   redirect_valid,
   input  logic [DATA_WIDTH-1:0]  redirect_pc,
   input  logic                   trap_valid,
   input  logic [DATA_WIDTH-1:0]  trap_vector,
   input  logic                   halt_req,
   input  logic                   resume,
   output logic [DATA_WIDTH-1:0]  pc_nxt,
   output my_pkg::pc_state_t      state_nxt,
   output logic                   misalign_nxt
);

   import my_pkg::*;

   localparam logic [DATA_WIDTH-1:0] INCR = DATA_WIDTH'(PC_INCR);
   localparam logic [DATA_WIDTH-1:0] MASK = ~(INCR - 1'b1);

   logic accept;

   assign accept = fetch_valid && fetch_ready && !stall;

   always_comb begin
      pc_nxt       = pc;
      state_nxt    = state;
      misalign_nxt = 1'b0;
      if (trap_valid) begin
         pc_nxt    = trap_vector & MASK;
         state_nxt = RUN;
      end else begin
         unique case (state)
            RESET: state_nxt = RUN;
            RUN: begin
               if (redirect_valid) begin
`ifdef PC_MISALIGN_TRAP_EN
                  if ((redirect_pc & ~MASK) != '0) begin
                     misalign_nxt = 1'b1;
                  end else begin
                     pc_nxt = redirect_pc;
                  end
`else
                  pc_nxt = redirect_pc & MASK;
`endif
               end else if (halt_req) begin
                  state_nxt = HALT;
               end else if (accept) begin
                  pc_nxt = pc + INCR;
               end
            end
            HALT: begin
               // a simultaneous halt_req keeps the core parked
               if (resume && !halt_req) begin
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RESET;
         endcase
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: reset/run/halt control and fetch request.
// Define PC_MISALIGN_TRAP_EN to flag misaligned redirects via misalign_exc.
module pc_gen #(
   parameter int                  DATA_WIDTH   = my_pkg::DATA_WIDTH,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR =
      DATA_WIDTH'(my_pkg::RESET_VECTOR),
   parameter int                  PC_INCR      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  trap_valid,
   input  logic [DATA_WIDTH-1:0] trap_vector,
   input  logic                  halt_req,
   input  logic                  resume,
   pc_gen_if.master              fetch,
   output logic [DATA_WIDTH-1:0] pc_next_seq,
   output logic                  halted,
   output logic                  misalign_exc
);

   import my_pkg::*;

   pc_state_t             state;
   pc_state_t             state_nxt;
   logic [DATA_WIDTH-1:0] pc;
   logic [DATA_WIDTH-1:0] pc_nxt;
   logic                  valid;
   logic                  misalign_nxt;

   pc_next_sel #(
      .DATA_WIDTH (DATA_WIDTH),
      .PC_INCR    (PC_INCR)
   ) u_sel (
      .state          (state),
      .pc             (pc),
      .fetch_valid    (valid),
      .fetch_ready    (fetch.fetch_ready),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .trap_valid     (trap_valid),
      .trap_vector    (trap_vector),
      .halt_req       (halt_req),
      .resume         (resume),
      .pc_nxt         (pc_nxt),
      .state_nxt      (state_nxt),
      .misalign_nxt   (misalign_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RESET;
         pc           <= RESET_VECTOR;
         valid        <= 1'b0;
         halted       <= 1'b0;
         misalign_exc <= 1'b0;
      end else begin
         state        <= state_nxt;
         pc           <= pc_nxt;
         valid        <= (state_nxt == RUN);
         halted       <= (state_nxt == HALT);
         misalign_exc <= misalign_nxt;
      end
   end

   assign fetch.fetch_valid = valid;
   assign fetch.fetch_pc    = pc;
   assign pc_next_seq       = pc + DATA_WIDTH'(PC_INCR);

endmodule

// File: tb/tb_pc_gen.sv
// Directed testbench for pc_gen with hand-computed expected values.
// Covers both builds of PC_MISALIGN_TRAP_EN.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        trap_valid;
   logic [31:0] trap_vector;
   logic        halt_req;
   logic        resume;
   logic [31:0] pc_next_seq;
   logic        halted;
   logic        misalign_exc;

   int n_pass  = 0;
   int n_total = 0;

   pc_gen_if #(.DATA_WIDTH(32)) fetch ();

   pc_gen dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .trap_valid     (trap_valid),
      .trap_vector    (trap_vector),
      .halt_req       (halt_req),
      .resume         (resume),
      .fetch          (fetch.master),
      .pc_next_seq    (pc_next_seq),
      .halted         (halted),
      .misalign_exc   (misalign_exc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_st(input string tag, input logic [31:0] pc,
                         input logic v, input logic h);
      chk({tag, ".pc"}, fetch.fetch_pc, pc);
      chk({tag, ".valid"}, 32'(fetch.fetch_valid), 32'(v));
      chk({tag, ".halted"}, 32'(halted), 32'(h));
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      trap_valid = 1'b0;
      trap_vector = '0;
      halt_req = 1'b0;
      resume = 1'b0;
      fetch.fetch_ready = 1'b1;

      repeat (3) step();
      chk_st("reset", 32'h1000, 1'b0, 1'b0);
      chk("reset.mis", 32'(misalign_exc), 32'd0);

      rst = 1'b0;
      step();
      chk_st("run0", 32'h1000, 1'b1, 1'b0);
      step();
      chk_st("run1", 32'h1004, 1'b1, 1'b0);
      step();
      chk_st("run2", 32'h1008, 1'b1, 1'b0);

      fetch.fetch_ready = 1'b0;
      step();
      chk("nrdy0", fetch.fetch_pc, 32'h1008);
      step();
      chk("nrdy1", fetch.fetch_pc, 32'h1008);
      fetch.fetch_ready = 1'b1;
      step();
      chk("rdy", fetch.fetch_pc, 32'h100C);
      chk("seq", pc_next_seq, 32'h1010);
      step();
      chk("pc1010", fetch.fetch_pc, 32'h1010);

      halt_req = 1'b1;
      step();
      halt_req = 1'b0;
      chk_st("halt", 32'h1010, 1'b0, 1'b1);
      repeat (4) step();
      chk_st("halt4", 32'h1010, 1'b0, 1'b1);
      resume = 1'b1;
      step();
      resume = 1'b0;
      chk_st("resume", 32'h1010, 1'b1, 1'b0);

      trap_valid = 1'b1;
      trap_vector = 32'h2003;
      redirect_valid = 1'b1;
      redirect_pc = 32'h3000;
      stall = 1'b1;
      step();
      trap_valid = 1'b0;
      redirect_valid = 1'b0;
      stall = 1'b0;
      chk_st("trap", 32'h2000, 1'b1, 1'b0);
      step();
      chk("trap+1", fetch.fetch_pc, 32'h2004);

      redirect_valid = 1'b1;
      redirect_pc = 32'h4002;
      step();
      redirect_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      chk("mis.pc", fetch.fetch_pc, 32'h2004);
      chk("mis.exc", 32'(misalign_exc), 32'd1);
      step();
      chk("mis.pc1", fetch.fetch_pc, 32'h2008);
      chk("mis.exc1", 32'(misalign_exc), 32'd0);
`else
      chk("mis.pc", fetch.fetch_pc, 32'h4000);
      chk("mis.exc", 32'(misalign_exc), 32'd0);
      step();
      chk("mis.pc1", fetch.fetch_pc, 32'h4004);
      chk("mis.exc1", 32'(misalign_exc), 32'd0);
`endif

      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      chk("wrap.pc", fetch.fetch_pc, 32'hFFFF_FFFC);
      chk("wrap.seq", pc_next_seq, 32'h0000_0000);
      step();
      chk("wrap", fetch.fetch_pc, 32'h0000_0000);

      stall = 1'b1;
      step();
      stall = 1'b0;
      chk("stall", fetch.fetch_pc, 32'h0000_0000);

      halt_req = 1'b1;
      step();
      resume = 1'b1;
      step();
      chk_st("hold_both", 32'h0000_0000, 1'b0, 1'b1);
      halt_req = 1'b0;
      resume = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h5000;
      step();
      redirect_valid = 1'b0;
      chk_st("halt_redir", 32'h0000_0000, 1'b0, 1'b1);

      rst = 1'b1;
      step();
      chk_st("rst_halt", 32'h1000, 1'b0, 1'b0);
      rst = 1'b0;
      step();
      chk_st("rst_run", 32'h1000, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
